// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
//   grant_e           : the source that wins the write port in a cycle
//   DEFAULT_TRIG_REG  : register written by a trigger grant (t0 / x5)
//   DEFAULT_TRIG_VALUE: value written by a trigger grant
package rf_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2,
    GNT_TRIG = 2'd3
  } grant_e;

  localparam int unsigned DEFAULT_TRIG_REG   = 5;
  localparam int unsigned DEFAULT_TRIG_VALUE = 1;

endpackage

// File: rtl/rf_wb_buffer.sv
// One-entry holding buffer in front of the register-file write port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   valid/ready       : writeback handshake (ready is combinational)
//   addr, data        : offered write
//   grant             : the arbiter is draining this buffer this cycle
//   buf_valid/addr/data: buffered write presented to the arbiter
// A write to x0 is accepted and discarded so it never reaches the port.
module rf_wb_buffer #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  output logic                     ready,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     grant,
  output logic                     buf_valid,
  output logic [ADDRESS_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0]    buf_data
);

  logic load;

  // A granted buffer frees its slot in the same cycle, so a requester
  // granted every cycle can hand over a new write every cycle.
  assign ready = rst_n & (~buf_valid | grant);
  assign load  = valid & ready & (addr != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, regardless of block ordering.
  // NOTE: the payload is reset too; it is a single entry, and a known
  // value keeps the arbiter inputs clean right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (load) begin
      // Load wins over drain: granted and reloaded stays valid.
      buf_valid <= 1'b1;
      buf_addr  <= addr;
      buf_data  <= data;
    end else if (grant) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Sole driver of the register-file write port. Arbitrates between two
// buffered writeback requesters (round-robin) and an external trigger
// that writes TRIG_VALUE to TRIG_REG, with a starvation guard for it.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req0_* / req1_*            : ALU / load writeback handshakes
//   trigger                    : level; any high cycle requests a t0 write
//   we3, a3, wd3               : registered register-file write port
//   trig_pending               : trigger request not yet granted
//   busy                       : buffer valid, trigger pending or we3 high
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 5,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned TRIG_REG      = DEFAULT_TRIG_REG,
  parameter int unsigned TRIG_VALUE    = DEFAULT_TRIG_VALUE,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_data,
  input  logic                     trigger,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     trig_pending,
  output logic                     busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  grant_e                   grant;
  logic                     buf0_valid, buf1_valid;
  logic [ADDRESS_WIDTH-1:0] buf0_addr, buf1_addr;
  logic [DATA_WIDTH-1:0]    buf0_data, buf1_data;
  logic                     trig_pend;
  logic [SW-1:0]            starve_cnt;
  logic                     rr;

  rf_wb_buffer #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req0_valid),
    .ready     (req0_ready),
    .addr      (req0_addr),
    .data      (req0_data),
    .grant     (grant == GNT_REQ0),
    .buf_valid (buf0_valid),
    .buf_addr  (buf0_addr),
    .buf_data  (buf0_data)
  );

  rf_wb_buffer #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req1_valid),
    .ready     (req1_ready),
    .addr      (req1_addr),
    .data      (req1_data),
    .grant     (grant == GNT_REQ1),
    .buf_valid (buf1_valid),
    .buf_addr  (buf1_addr),
    .buf_data  (buf1_data)
  );

  // Priority: starved trigger, then buffers (round-robin), then idle trigger.
  // NOTE: grant is assigned a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (trig_pend && starve_cnt == STARVE_MAX) grant = GNT_TRIG;
    else if (buf0_valid && buf1_valid)         grant = rr ? GNT_REQ1 : GNT_REQ0;
    else if (buf0_valid)                       grant = GNT_REQ0;
    else if (buf1_valid)                       grant = GNT_REQ1;
    else if (trig_pend)                        grant = GNT_TRIG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_pend  <= 1'b0;
      starve_cnt <= '0;
      rr         <= 1'b0;
    end else begin
      // A trigger in the grant cycle is a fresh request, so set wins.
      if (trigger)                trig_pend <= 1'b1;
      else if (grant == GNT_TRIG) trig_pend <= 1'b0;

      if (!trig_pend || grant == GNT_TRIG) starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)   starve_cnt <= starve_cnt + 1'b1;

      // After a buffer grant the other requester gets priority; a trigger
      // grant leaves the rotation untouched.
      if (grant == GNT_REQ0)      rr <= 1'b1;
      else if (grant == GNT_REQ1) rr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= (grant != GNT_NONE);
      unique case (grant)
        GNT_REQ0: begin a3 <= buf0_addr; wd3 <= buf0_data; end
        GNT_REQ1: begin a3 <= buf1_addr; wd3 <= buf1_data; end
        GNT_TRIG: begin
          a3  <= ADDRESS_WIDTH'(TRIG_REG);
          wd3 <= DATA_WIDTH'(TRIG_VALUE);
        end
        default: ;  // no grant: address and data hold
      endcase
    end
  end

  assign trig_pending = trig_pend;
  assign busy         = buf0_valid | buf1_valid | trig_pend | we3;

endmodule
